seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle shift-subtract divider. It is the producer side of the Hi/Lo result interface.
- Takes a 32-bit dividend and divisor on a start pulse and iterates one quotient bit per clock.
- Presents the 64-bit result bus DivAns: upper half = remainder (Hi), lower half = quotient (Lo).
- Pulses done for exactly one cycle when the result is valid, so the Hi/Lo holding register can capture it.

Parameters:
- WIDTH, 32, operand width; DivAns is 2*WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- start  in  1  request; sampled only in IDLE.
- dividend  in  WIDTH  numerator, sampled with start.
- divisor  in  WIDTH  denominator, sampled with start.
- div_signed  in  1  signed-operation select (present only with SEQ_DIV_SIGNED_EN).
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle result-valid pulse.
- div_zero  out  1  divisor was 0; valid with done, held with DivAns.
- DivAns  out  2*WIDTH  {remainder, quotient}.

Behaviour:
- Reset (reset==0 at posedge clk): state=IDLE, busy=0, done=0, div_zero=0, DivAns=0, counter=0. This overrides any operation in flight; no partial result is ever emitted.
- States: IDLE, RUN, DONE, encoded as 2 bits.
- IDLE, start=1, divisor!=0:
  - Latch operands; rem=0, quo=dividend, cnt=0.
  - Go to RUN.
- IDLE, start=1, divisor==0:
  - Go directly to DONE.
  - DivAns={dividend, all-ones}, div_zero=1.
- RUN, each cycle (restoring algorithm):
  - {rem,quo} shifted left 1.
  - If shifted rem >= divisor: rem -= divisor, quo[0]=1; else quo[0]=0.
  - cnt++.
  - After the WIDTH-th iteration (cnt==WIDTH-1 this cycle), go to DONE.
- DONE:
  - done=1 for this single cycle; DivAns={rem,quo}.
  - Next edge returns to IDLE.
- Latency: done is high exactly WIDTH+1 clock edges after the edge that sampled start (33 for WIDTH=32). For divide-by-zero it is 1 edge.
- DivAns and div_zero hold their value until the next accepted start. On that start they are NOT cleared until the new result is written in DONE.
- start while busy=1 is ignored; no queuing.
- start in the DONE cycle is ignored. A new start is accepted in the IDLE cycle after done, giving a minimum issue interval of WIDTH+2 cycles.
- Operand inputs may change after the start edge without effect.
- Subtraction uses a WIDTH+1-bit compare so divisor values >= 2^(WIDTH-1) are correct.
- Arithmetic is unsigned unless the optional feature is enabled.

Optional Feature:
- Macro: SEQ_DIV_SIGNED_EN.
- Defined:
  - div_signed port exists.
  - When div_signed=1 at start, operands are converted to magnitudes and the core runs unsigned.
  - In DONE, the quotient is negated if the operand signs differ; the remainder takes the sign of the dividend.
  - Most-negative / -1 gives quotient=0x80000000, remainder=0.
  - Divide-by-zero behaviour is the same as unsigned (quotient all-ones, remainder=dividend raw bits).
  - Adds one sign-fix step inside DONE only; latency is unchanged.
- Undefined: port absent; all division is unsigned.

Decomposition:
- Package seq_div_pkg:
  - state enum (IDLE/RUN/DONE).
  - default WIDTH.
  - DIV_ZERO_QUO constant (all-ones).
- Sub-module div_step: purely combinational single iteration. Inputs rem, quo, divisor; outputs next rem, next quo. Instantiated once in RUN.
- FSM, counter and sign handling stay in seq_divider.

Test Plan:
- 100 / 7 unsigned, start for 1 cycle → done exactly 33 edges later; DivAns = {32'd2, 32'd14}; div_zero=0; busy high 33 cycles.
- 0xFFFFFFFF / 0x80000000 → DivAns = {32'h7FFFFFFF, 32'h1}. Checks the wide-compare path.
- 55 / 0 → done 1 edge after start; div_zero=1; DivAns = {32'd55, 32'hFFFFFFFF}. Then 9 / 3 → div_zero returns to 0, DivAns = {0, 3}.
- Reset mid-operation: start 1000/3, drive reset=0 at cycle 10 → next edge has busy=0, done=0, DivAns=0. No done pulse ever follows. A new start after release divides correctly.
- Start pulsed at cycles 5, 20 and 33 (DONE) of an operation → all ignored. A start on the IDLE cycle after done is accepted. Results match the first operands only.
- (SEQ_DIV_SIGNED_EN) -7 / 2, div_signed=1 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- (SEQ_DIV_SIGNED_EN) 7 / -2 → quotient 0xFFFFFFFD, remainder 1.
- (SEQ_DIV_SIGNED_EN) same -7 / 2 operands with div_signed=0 → unsigned result.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential shift-subtract divider.
package seq_div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  // Quotient reported for a zero divisor.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, conditionally subtract divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           ge;

  // Compare on WIDTH+1 bits so a shifted-out remainder MSB is not lost.
  always_comb begin
    rem_sh = {rem_i, quo_i[WIDTH-1]};
    diff   = rem_sh - {1'b0, divisor_i};
    ge     = (rem_sh >= {1'b0, divisor_i});
    rem_o  = WIDTH'(ge ? diff : rem_sh);
    quo_o  = {quo_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle divider producing {remainder, quotient} on DivAns with a one-cycle done pulse.
// Optional signed division is enabled by defining SEQ_DIV_SIGNED_EN.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic               div_signed,
`endif
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic [2*WIDTH-1:0] DivAns
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic [2*WIDTH-1:0] ans_q, ans_d;

  logic [WIDTH-1:0]   step_rem, step_quo;
  logic [WIDTH-1:0]   dnd_mag, dvs_mag;
  logic               quo_negate, rem_negate;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

`ifdef SEQ_DIV_SIGNED_EN
  always_comb begin
    dnd_mag    = (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_mag    = (div_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    quo_negate = div_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
    rem_negate = div_signed && dividend[WIDTH-1];
  end
`else
  always_comb begin
    dnd_mag    = dividend;
    dvs_mag    = divisor;
    quo_negate = 1'b0;
    rem_negate = 1'b0;
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    ans_d      = ans_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          cnt_d  = '0;
          dvs_d  = dvs_mag;
          if (divisor == '0) begin
            // Zero divisor bypasses the core; sign fix is suppressed so raw bits survive.
            zero_d  = 1'b1;
            neg_d   = 1'b0;
            rneg_d  = 1'b0;
            rem_d   = dividend;
            quo_d   = '1;
            state_d = DONE;
          end else begin
            zero_d  = 1'b0;
            neg_d   = quo_negate;
            rneg_d  = rem_negate;
            rem_d   = '0;
            quo_d   = dnd_mag;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        div_zero_d = zero_q;
        ans_d      = {(rneg_q ? -rem_q : rem_q), (neg_q ? -quo_q : quo_q)};
        state_d    = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      ans_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      ans_q      <= ans_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign DivAns   = ans_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (unsigned path, plus signed vectors when SEQ_DIV_SIGNED_EN is defined).
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        div_signed;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [63:0] DivAns;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
`ifdef SEQ_DIV_SIGNED_EN
    .div_signed (div_signed),
`endif
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .DivAns     (DivAns)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents operands on a negedge, lets one posedge sample them, then scrambles the inputs.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    @(negedge clk);
    dividend   = a;
    divisor    = b;
    div_signed = sgn;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start      = 1'b0;
    dividend   = $urandom;
    divisor    = $urandom;
    div_signed = ~sgn;
  endtask

  // Counts edges from the start edge until done; optional poke issues starts that must be ignored.
  task automatic wait_done(input bit poke, output int lat, output int bsy);
    lat = 0;
    bsy = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bsy++;
      start = poke && (lat == 5 || lat == 20 || lat == 32);
      if (start) begin
        dividend = 32'd5;
        divisor  = 32'd5;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [63:0] exp_ans, input logic exp_zero, input int exp_lat);
    int lat, bsy;
    logic [63:0] held_ans;
    logic        held_zero;
    held_ans  = DivAns;
    held_zero = div_zero;
    launch(a, b, sgn);
    check_eq({tag, "_held_ans"}, DivAns, held_ans);
    check_eq({tag, "_held_zero"}, 64'(div_zero), 64'(held_zero));
    wait_done(1'b0, lat, bsy);
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_busy_cycles"}, 64'(bsy), 64'(exp_lat));
    check_eq({tag, "_ans"}, DivAns, exp_ans);
    check_eq({tag, "_zero"}, 64'(div_zero), 64'(exp_zero));
    check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    check_eq({tag, "_done_single"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat, bsy, n_done;
    reset      = 1'b0;
    start      = 1'b0;
    dividend   = '0;
    divisor    = '0;
    div_signed = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_zero", 64'(div_zero), 64'd0);
    check_eq("rst_ans", DivAns, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_div("d100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 1'b0, 33);
    run_div("wide", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, {32'h7FFF_FFFF, 32'h1}, 1'b0, 33);
    run_div("dz55", 32'd55, 32'd0, 1'b0, {32'd55, 32'hFFFF_FFFF}, 1'b1, 1);
    run_div("d9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 1'b0, 33);

    // Reset in the middle of a division.
    launch(32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_done", 64'(done), 64'd0);
    check_eq("midrst_ans", DivAns, 64'd0);
    check_eq("midrst_zero", 64'(div_zero), 64'd0);
    reset  = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check_eq("midrst_no_done", 64'(n_done), 64'd0);
    run_div("d1000_3", 32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 1'b0, 33);

    // Starts while busy (including the DONE cycle) are dropped; start on the done cycle is taken.
    launch(32'd200, 32'd9, 1'b0);
    wait_done(1'b1, lat, bsy);
    check_eq("ign_latency", 64'(lat), 64'd33);
    check_eq("ign_ans", DivAns, {32'd2, 32'd22});
    dividend = 32'd81;
    divisor  = 32'd4;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    check_eq("b2b_busy", 64'(busy), 64'd1);
    check_eq("b2b_held_ans", DivAns, {32'd2, 32'd22});
    wait_done(1'b0, lat, bsy);
    check_eq("b2b_latency", 64'(lat), 64'd33);
    check_eq("b2b_ans", DivAns, {32'd1, 32'd20});
    @(negedge clk);

`ifdef SEQ_DIV_SIGNED_EN
    run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 33);
    run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 1'b0, 33);
    run_div("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, {32'd1, 32'h7FFF_FFFC}, 1'b0, 33);
    run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 1'b0, 33);
    run_div("s_dz", 32'hFFFF_FFF9, 32'd0, 1'b1, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1'b1, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
